// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: reconfiguration controller for a programmable clock divider.
// Arbitrates divide-ratio change requests round-robin, validates them, and
// applies an accepted ratio only at a falling edge of the divided clock. The
// divider phase is then restarted with a one-cycle reset, a settle window is
// allowed to elapse, and the owning requester receives a one-cycle ack.
module clkdiv_ctrl #(
    parameter int N           = 4,
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 7,
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT     = 512
) (
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic [N-1:0]           req,
    input  logic [N*WIDTH-1:0]     req_div,
    input  logic                   clk_div_in,
    output logic [WIDTH-1:0]       div_out,
    output logic                   div_rst,
    output logic [N-1:0]           ack,
    output logic                   err,
    output logic                   busy,
    output logic [$clog2(N)-1:0]   owner
);

    localparam int OW      = $clog2(N);
    localparam int CNT_MAX = (TIMEOUT > SETTLE_CYC) ? TIMEOUT : SETTLE_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0]    TO_LAST     = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]    SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [WIDTH-1:0] DEF_DIV     = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] MIN_DIV     = WIDTH'(2);

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_IDLE      = 3'd1,
        ST_WAIT_EDGE = 3'd2,
        ST_LOAD      = 3'd3,
        ST_SETTLE    = 3'd4,
        ST_ACK       = 3'd5
    } state_t;

    state_t            state_r;
    logic [OW-1:0]     rr_r;
    logic [WIDTH-1:0]  pend_r;
    logic              prev_r;
    logic [CW-1:0]     cnt_r;

    logic              any_req_s;
    logic [OW-1:0]     grant_s;
    logic [OW-1:0]     next_rr_s;
    logic [WIDTH-1:0]  pend_sel_s;
    logic              fall_s;
    logic              hit_s;
    logic [OW-1:0]     cand_s;
    int                cand_i;

    // One-hot ack vector for the given requester index.
    function automatic logic [N-1:0] onehot(input logic [OW-1:0] idx);
        onehot = {{(N-1){1'b0}}, 1'b1} << idx;
    endfunction

    // A falling edge of the divided clock: sampled high last cycle, low now.
    assign fall_s = prev_r & ~clk_div_in;

    // Round-robin pick: first set request at or after the pointer, wrapping.
    always_comb begin
        any_req_s  = 1'b0;
        grant_s    = {OW{1'b0}};
        cand_i     = 0;
        cand_s     = {OW{1'b0}};
        hit_s      = 1'b0;
        pend_sel_s = {WIDTH{1'b0}};
        for (int k = 0; k < N; k++) begin
            cand_i    = (int'(rr_r) + k) % N;
            cand_s    = OW'(cand_i);
            hit_s     = ~any_req_s & req[cand_s];
            grant_s   = hit_s ? cand_s : grant_s;
            any_req_s = any_req_s | hit_s;
        end
        for (int k = 0; k < N; k++) begin
            pend_sel_s = (OW'(k) == grant_s) ? req_div[k*WIDTH +: WIDTH] : pend_sel_s;
        end
    end

    // Pointer advances past the granted requester, wrapping at N.
    assign next_rr_s = (grant_s == OW'(N - 1)) ? {OW{1'b0}} : grant_s + OW'(1);

    // Main control FSM with all outputs registered. The validity and
    // no-change checks are made on the latched ratio in the first cycle after
    // the grant, keeping the request mux out of the compare path.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_r <= ST_INIT;
            rr_r    <= {OW{1'b0}};
            pend_r  <= DEF_DIV;
            prev_r  <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            div_out <= DEF_DIV;
            div_rst <= 1'b1;
            ack     <= {N{1'b0}};
            err     <= 1'b0;
            busy    <= 1'b1;
            owner   <= {OW{1'b0}};
        end else begin
            prev_r <= clk_div_in;
            ack    <= {N{1'b0}};
            err    <= 1'b0;
            case (state_r)
                ST_INIT: begin
                    state_r <= ST_IDLE;
                    div_rst <= 1'b0;
                    busy    <= 1'b0;
                end
                ST_IDLE: begin
                    if (any_req_s) begin
                        owner   <= grant_s;
                        pend_r  <= pend_sel_s;
                        rr_r    <= next_rr_s;
                        cnt_r   <= {CW{1'b0}};
                        busy    <= 1'b1;
                        state_r <= ST_WAIT_EDGE;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                ST_WAIT_EDGE: begin
                    if (pend_r < MIN_DIV) begin
                        ack     <= onehot(owner);
                        err     <= 1'b1;
                        state_r <= ST_ACK;
                    end else if (pend_r == div_out) begin
                        ack     <= onehot(owner);
                        state_r <= ST_ACK;
                    end else if (fall_s || (cnt_r == TO_LAST)) begin
                        div_out <= pend_r;
                        div_rst <= 1'b1;
                        cnt_r   <= {CW{1'b0}};
                        state_r <= ST_LOAD;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                    end
                end
                ST_LOAD: begin
                    div_rst <= 1'b0;
                    cnt_r   <= {CW{1'b0}};
                    state_r <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt_r == SETTLE_LAST) begin
                        ack     <= onehot(owner);
                        state_r <= ST_ACK;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                    end
                end
                ST_ACK: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    div_rst <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Directed testbench for clkdiv_ctrl with a behavioural divider model that
// feeds clk_div_in from div_out/div_rst.
module tb_clkdiv_ctrl;

    localparam int N = 4;
    localparam int W = 8;

    logic          clk_in;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*W-1:0] req_div;
    logic          clk_div_in;
    logic [W-1:0]  div_out;
    logic          div_rst;
    logic [N-1:0]  ack;
    logic          err;
    logic          busy;
    logic [1:0]    owner;

    logic          div_clk_r = 1'b0;
    int            dcnt      = 0;
    logic          stuck     = 1'b0;

    int            cyc       = 0;
    logic          div_prev  = 1'b0;
    logic          div_now   = 1'b0;
    int            n_total   = 0;
    int            n_pass    = 0;

    clkdiv_ctrl #(
        .N(N), .WIDTH(W), .DEFAULT_DIV(7), .SETTLE_CYC(4), .TIMEOUT(512)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .req        (req),
        .req_div    (req_div),
        .clk_div_in (clk_div_in),
        .div_out    (div_out),
        .div_rst    (div_rst),
        .ack        (ack),
        .err        (err),
        .busy       (busy),
        .owner      (owner)
    );

    // System clock.
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Divider model: output toggles every div_out input clocks; reset holds it low.
    always @(posedge clk_in) begin
        if (div_rst) begin
            dcnt      <= 0;
            div_clk_r <= 1'b0;
        end else if (dcnt >= int'(div_out) - 1) begin
            dcnt      <= 0;
            div_clk_r <= ~div_clk_r;
        end else begin
            dcnt      <= dcnt + 1;
        end
    end

    assign clk_div_in = div_clk_r & ~stuck;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total = n_total + 1;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass = n_pass + 1;
        end
    endtask

    // Advance to the next sample point (falling edge of clk_in).
    task automatic step();
        @(negedge clk_in);
        cyc      = cyc + 1;
        div_prev = div_now;
        div_now  = clk_div_in;
    endtask

    // Step until an ack pulse, recording first divided-clock fall after the
    // grant, the first div_rst cycle and the number of div_rst cycles.
    task automatic wait_ack(input int g, input int budget,
                            output int ack_c, output int load_c, output int fall_c,
                            output int pulses, output logic [W-1:0] div_at_load,
                            output logic [N-1:0] ackv, output logic errv,
                            output logic [1:0] own);
        ack_c = -1; load_c = -1; fall_c = -1; pulses = 0;
        div_at_load = '0; ackv = '0; errv = 1'b0; own = 2'd0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (fall_c < 0 && load_c < 0 && cyc >= g + 1 && div_prev && !div_now) fall_c = cyc;
            if (div_rst) begin
                pulses = pulses + 1;
                if (load_c < 0) begin
                    load_c      = cyc;
                    div_at_load = div_out;
                end
            end
            if (ack != '0) begin
                ack_c = cyc;
                ackv  = ack;
                errv  = err;
                own   = owner;
                break;
            end
        end
        check_eq("ack_seen", 32'(ack_c >= 0), 32'd1);
    endtask

    initial begin
        int a_c, l_c, f_c, pul, g, r0, f0;
        logic [W-1:0] dl;
        logic [N-1:0] av;
        logic ev;
        logic [1:0] ow;
        int exp_own [3];
        int exp_div [3];
        logic [N-1:0] exp_ack [3];

        exp_own[0] = 0; exp_own[1] = 1; exp_own[2] = 3;
        exp_div[0] = 5; exp_div[1] = 6; exp_div[2] = 9;
        exp_ack[0] = 4'b0001; exp_ack[1] = 4'b0010; exp_ack[2] = 4'b1000;

        req = '0; req_div = '0; rst = 1'b1;
        #2 rst = 1'b0;

        // Reset values
        step();
        check_eq("rst_div_out", 32'(div_out), 32'd7);
        check_eq("rst_div_rst", 32'(div_rst), 32'd1);
        check_eq("rst_busy",    32'(busy),    32'd1);
        check_eq("rst_ack",     32'(ack),     32'd0);
        check_eq("rst_err",     32'(err),     32'd0);
        check_eq("rst_owner",   32'(owner),   32'd0);

        // Release: INIT cycle keeps div_rst high, then IDLE
        step();
        rst = 1'b1;
        check_eq("init_div_rst", 32'(div_rst), 32'd1);
        step();
        check_eq("idle_div_rst", 32'(div_rst), 32'd0);
        check_eq("idle_busy",    32'(busy),    32'd0);
        check_eq("idle_div_out", 32'(div_out), 32'd7);

        // Divided clock half period equals the default ratio
        r0 = -1; f0 = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (r0 < 0 && !div_prev && div_now) r0 = cyc;
            else if (r0 >= 0 && div_prev && !div_now) begin
                f0 = cyc;
                break;
            end
        end
        check_eq("div_half_period", 32'(f0 - r0), 32'd7);

        // Simultaneous requests 0,1,3: grant order 0,1,3
        req_div = {8'd9, 8'd0, 8'd6, 8'd5};
        req     = 4'b1011;
        g       = cyc;
        for (int k = 0; k < 3; k++) begin
            wait_ack(g, 200, a_c, l_c, f_c, pul, dl, av, ev, ow);
            check_eq("rr_ack",       32'(av),  32'(exp_ack[k]));
            check_eq("rr_owner",     32'(ow),  32'(exp_own[k]));
            check_eq("rr_err",       32'(ev),  32'd0);
            check_eq("rr_load_lat",  32'(l_c), 32'(f_c + 1));
            check_eq("rr_ack_lat",   32'(a_c), 32'(f_c + 6));
            check_eq("rr_div_load",  32'(dl),  32'(exp_div[k]));
            req = req & ~av;
            step();
            check_eq("rr_idle_gap",  32'(busy),    32'd0);
            check_eq("rr_div_out",   32'(div_out), 32'(exp_div[k]));
            g = cyc;
        end

        // Single request on requester 2, ratio 4
        req_div[23:16] = 8'd4;
        req = 4'b0100;
        g   = cyc;
        wait_ack(g, 200, a_c, l_c, f_c, pul, dl, av, ev, ow);
        check_eq("one_fall_seen", 32'(f_c >= 0), 32'd1);
        check_eq("one_load_lat",  32'(l_c), 32'(f_c + 1));
        check_eq("one_div_load",  32'(dl),  32'd4);
        check_eq("one_ack_lat",   32'(a_c), 32'(f_c + 6));
        check_eq("one_ack",       32'(av),  32'b0100);
        check_eq("one_err",       32'(ev),  32'd0);
        check_eq("one_owner",     32'(ow),  32'd2);
        check_eq("one_rst_pulse", 32'(pul), 32'd1);
        req = '0;
        step();

        // Invalid ratio 1 on requester 3: reject, no reload
        req_div[31:24] = 8'd1;
        req = 4'b1000;
        g   = cyc;
        wait_ack(g, 20, a_c, l_c, f_c, pul, dl, av, ev, ow);
        check_eq("bad_ack_lat", 32'(a_c),     32'(g + 2));
        check_eq("bad_err",     32'(ev),      32'd1);
        check_eq("bad_ack",     32'(av),      32'b1000);
        check_eq("bad_owner",   32'(ow),      32'd3);
        check_eq("bad_no_rst",  32'(pul),     32'd0);
        check_eq("bad_div_out", 32'(div_out), 32'd4);
        req = '0;
        step();

        // Same ratio as current on requester 0: ack ok, no reload
        req_div[7:0] = 8'd4;
        req = 4'b0001;
        g   = cyc;
        wait_ack(g, 20, a_c, l_c, f_c, pul, dl, av, ev, ow);
        check_eq("same_ack_lat", 32'(a_c),     32'(g + 2));
        check_eq("same_err",     32'(ev),      32'd0);
        check_eq("same_ack",     32'(av),      32'b0001);
        check_eq("same_no_rst",  32'(pul),     32'd0);
        check_eq("same_div_out", 32'(div_out), 32'd4);
        req = '0;
        step();

        // Stuck divider: reload forced by timeout
        for (int i = 0; i < 20; i++) begin
            if (clk_div_in == 1'b0) break;
            step();
        end
        check_eq("stuck_low", 32'(clk_div_in), 32'd0);
        stuck = 1'b1;
        req_div[15:8] = 8'd3;
        req = 4'b0010;
        g   = cyc;
        wait_ack(g, 600, a_c, l_c, f_c, pul, dl, av, ev, ow);
        check_eq("to_load_lat", 32'(l_c), 32'(g + 513));
        check_eq("to_ack_lat",  32'(a_c), 32'(g + 518));
        check_eq("to_err",      32'(ev),  32'd0);
        check_eq("to_ack",      32'(av),  32'b0010);
        check_eq("to_div_load", 32'(dl),  32'd3);
        req   = '0;
        stuck = 1'b0;
        step();

        // Reset asserted during SETTLE, request re-granted afterwards
        req_div[23:16] = 8'd6;
        req = 4'b0100;
        for (int i = 0; i < 100; i++) begin
            step();
            if (div_rst) break;
        end
        check_eq("rs_load_seen", 32'(div_rst), 32'd1);
        step();
        step();
        rst = 1'b0;
        #1;
        check_eq("rs_div_out", 32'(div_out), 32'd7);
        check_eq("rs_div_rst", 32'(div_rst), 32'd1);
        check_eq("rs_busy",    32'(busy),    32'd1);
        check_eq("rs_ack",     32'(ack),     32'd0);
        check_eq("rs_owner",   32'(owner),   32'd0);
        step();
        check_eq("rs_hold_ack", 32'(ack), 32'd0);
        step();
        rst = 1'b1;
        g   = cyc + 1;
        wait_ack(g, 200, a_c, l_c, f_c, pul, dl, av, ev, ow);
        check_eq("rs_regrant_ack",   32'(av),  32'b0100);
        check_eq("rs_regrant_owner", 32'(ow),  32'd2);
        check_eq("rs_regrant_err",   32'(ev),  32'd0);
        check_eq("rs_load_lat",      32'(l_c), 32'(f_c + 1));
        check_eq("rs_ack_lat",       32'(a_c), 32'(f_c + 6));
        check_eq("rs_div_load",      32'(dl),  32'd6);
        req = '0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
